// File: rtl/minmax_seq.sv
// ============================================================================
// Module   : minmax_seq
// Brief    : Serial min/max search over an NI-word frame using one shared
//            two-input comparator; returns the winning value and its index.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module minmax_seq #(
   parameter int W    = 6,
   parameter int NI   = 7,
   parameter int IDXW = (NI > 1) ? $clog2(NI) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            cfg_us_sel,
   input  logic            cfg_min_max_sel,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_result,
   output logic [IDXW-1:0] out_index,
   output logic            busy
);

   localparam int CNTW = IDXW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      best_q, best_d;
   logic [IDXW-1:0]   best_idx_q, best_idx_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              us_q, us_d;
   logic              mm_q, mm_d;
   logic              accept;

   // True when a is strictly better than b; ties keep the incumbent.
   function automatic logic minmax2(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         signed_cmp,
      input logic         find_max
   );
      logic lt, gt;
      if (signed_cmp) begin
         lt = $signed(a) < $signed(b);
         gt = $signed(a) > $signed(b);
      end else begin
         lt = a < b;
         gt = a > b;
      end
      return find_max ? gt : lt;
   endfunction

   assign in_ready   = ((state_q == IDLE) || (state_q == ACC)) && !flush;
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign out_result = best_q;
   assign out_index  = best_idx_q;

   always_comb begin
      state_d    = state_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      cnt_d      = cnt_q;
      us_d       = us_q;
      mm_d       = mm_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  us_d       = cfg_us_sel;
                  mm_d       = cfg_min_max_sel;
                  best_d     = in_data;
                  best_idx_d = '0;
                  cnt_d      = CNTW'(1);
                  state_d    = (NI == 1) ? DONE : ACC;
               end
            end
            ACC: begin
               if (accept) begin
                  if (minmax2(in_data, best_q, us_q, mm_q)) begin
                     best_d     = in_data;
                     best_idx_d = cnt_q[IDXW-1:0];
                  end
                  cnt_d = cnt_q + CNTW'(1);
                  if (cnt_q == CNTW'(NI - 1)) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         best_q     <= '0;
         best_idx_q <= '0;
         cnt_q      <= '0;
         us_q       <= 1'b0;
         mm_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         cnt_q      <= cnt_d;
         us_q       <= us_d;
         mm_q       <= mm_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_minmax_seq.sv
// ============================================================================
// Module   : tb_minmax_seq
// Brief    : Self-checking bench for minmax_seq with a behavioural frame model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minmax_seq;

   localparam int W    = 6;
   localparam int NI   = 7;
   localparam int IDXW = 3;

   typedef logic [W-1:0] frame_t [NI];

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            cfg_us_sel = 1'b0;
   logic            cfg_min_max_sel = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [W-1:0]    out_result;
   logic [IDXW-1:0] out_index;
   logic            busy;

   int total = 0;
   int bad   = 0;

   minmax_seq #(.W(W), .NI(NI), .IDXW(IDXW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .cfg_us_sel(cfg_us_sel), .cfg_min_max_sel(cfg_min_max_sel),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_index(out_index), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: interpret each word as a number, pick the first extreme one.
   function automatic int as_num(input logic [W-1:0] v, input logic us);
      int n;
      n = int'(v);
      if (us && v[W-1]) n = n - (1 << W);
      return n;
   endfunction

   task automatic model(input frame_t v, input logic us, input logic mm,
                        output logic [W-1:0] val, output logic [IDXW-1:0] idx);
      int best, bi;
      best = as_num(v[0], us);
      bi   = 0;
      for (int i = 1; i < NI; i++) begin
         if (mm ? (as_num(v[i], us) > best) : (as_num(v[i], us) < best)) begin
            best = as_num(v[i], us);
            bi   = i;
         end
      end
      val = v[bi];
      idx = IDXW'(bi);
   endtask

   task automatic send_beat(input logic [W-1:0] d, input logic us, input logic mm, input string name);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; cfg_us_sel = us; cfg_min_max_sel = mm;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready got=%b want=1", name, in_ready); end
      @(posedge clk);
   endtask

   // Feed a whole frame, then check result, hold for `hold` cycles, handshake.
   task automatic run_frame(input frame_t v, input logic us, input logic mm, input logic scramble_cfg,
                            input int gap_pct, input int hold,
                            input logic [W-1:0] ev, input logic [IDXW-1:0] ei, input string name);
      for (int i = 0; i < NI; i++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = W'($urandom);
            cfg_us_sel = 1'($urandom); cfg_min_max_sel = 1'($urandom);
            @(posedge clk);
         end
         if (i == 0 || !scramble_cfg) send_beat(v[i], us, mm, name);
         else send_beat(v[i], 1'($urandom), 1'($urandom), name);
      end
      @(negedge clk);
      in_valid = 1'b0; in_data = W'($urandom);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid latency got=%b want=1", name, out_valid); end
      total++; if (out_result !== ev) begin bad++; $display("FAIL %s out_result got=%0d want=%0d", name, out_result, ev); end
      total++; if (out_index !== ei) begin bad++; $display("FAIL %s out_index got=%0d want=%0d", name, out_index, ei); end
      total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL %s done busy/in_ready got=%b/%b want=1/0", name, busy, in_ready); end
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom);
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_result !== ev || out_index !== ei || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s hold v/res/idx/rdy got=%b/%0d/%0d/%b want=1/%0d/%0d/0", name, out_valid, out_result, out_index, in_ready, ev, ei);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s after handshake valid/busy got=%b/%b want=0/0", name, out_valid, busy); end
   endtask

   task automatic check_reset_vals(input string name);
      total++;
      if (out_valid !== 1'b0 || out_result !== '0 || out_index !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s reset v/res/idx/busy/rdy got=%b/%0d/%0d/%b/%b want=0/0/0/0/1", name, out_valid, out_result, out_index, busy, in_ready);
      end
   endtask

   task automatic test_reset();
      #3;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_vals("reset_release");
   endtask

   task automatic test_modes();
      frame_t f;
      f = '{6'd5, 6'd63, 6'd0, 6'd12, 6'd63, 6'd0, 6'd7};
      run_frame(f, 1'b0, 1'b1, 1'b0, 0, 0, 6'd63, 3'd1, "umax");
      run_frame(f, 1'b0, 1'b0, 1'b0, 0, 0, 6'd0,  3'd2, "umin");
      run_frame(f, 1'b1, 1'b1, 1'b0, 0, 0, 6'd12, 3'd3, "smax");
      run_frame(f, 1'b1, 1'b0, 1'b0, 0, 0, 6'd63, 3'd1, "smin");
   endtask

   task automatic test_cfg_toggle();
      frame_t f;
      f = '{6'd5, 6'd63, 6'd0, 6'd12, 6'd63, 6'd0, 6'd7};
      send_beat(f[0], 1'b0, 1'b0, "cfg_toggle");
      for (int i = 1; i < NI; i++) send_beat(f[i], 1'b1, 1'b1, "cfg_toggle");
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_result !== 6'd0 || out_index !== 3'd2) begin bad++; $display("FAIL cfg_toggle v/res/idx got=%b/%0d/%0d want=1/0/2", out_valid, out_result, out_index); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_toggle busy got=%b want=0", busy); end
   endtask

   task automatic test_gaps_stall();
      frame_t f, g;
      logic [W-1:0] ev; logic [IDXW-1:0] ei;
      f = '{6'd20, 6'd3, 6'd40, 6'd3, 6'd17, 6'd9, 6'd33};
      model(f, 1'b0, 1'b1, ev, ei);
      run_frame(f, 1'b0, 1'b1, 1'b0, 40, 5, ev, ei, "gaps_max");
      g = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};
      run_frame(g, 1'b0, 1'b0, 1'b0, 40, 2, 6'd1, 3'd0, "gaps_ties");
   endtask

   task automatic test_flush();
      frame_t f;
      for (int i = 0; i < 4; i++) send_beat(W'(i + 30), 1'b0, 1'b0, "flush_pre");
      @(negedge clk);
      in_valid = 1'b1; in_data = 6'd0; flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush in_ready got=%b want=0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_after busy/valid got=%b/%b want=0/0", busy, out_valid); end
      f = '{6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3};
      run_frame(f, 1'b0, 1'b0, 1'b0, 0, 0, 6'd3, 3'd6, "flush_next");
      // Flush and out_ready together in DONE drops the result.
      for (int i = 0; i < NI; i++) send_beat(f[i], 1'b0, 1'b1, "flush_done");
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_done valid/busy got=%b/%b want=0/0", out_valid, busy); end
   endtask

   task automatic test_async_reset();
      frame_t f;
      for (int i = 0; i < 3; i++) send_beat(W'(50 + i), 1'b0, 1'b1, "areset_mid");
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("areset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++) send_beat(W'(40 + i), 1'b0, 1'b1, "areset_done");
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_done pre valid got=%b want=1", out_valid); end
      #2 rst_n = 1'b0;
      #1 check_reset_vals("areset_done");
      @(negedge clk);
      rst_n = 1'b1;
      f = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1};
      run_frame(f, 1'b0, 1'b1, 1'b0, 0, 0, 6'd1, 3'd6, "areset_next");
   endtask

   task automatic test_random();
      frame_t f;
      logic us, mm;
      logic [W-1:0] ev; logic [IDXW-1:0] ei;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < NI; i++)
            f[i] = (n % 2 == 0) ? W'($urandom) : W'($urandom_range(3) * 21);
         us = 1'($urandom); mm = 1'($urandom);
         model(f, us, mm, ev, ei);
         run_frame(f, us, mm, 1'b1, 30, $urandom_range(3), ev, ei, "random");
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_cfg_toggle();
      test_gaps_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/minmax_seq.md
# minmax_seq

Serial min/max search controller that shares one two-input comparator (the `minmax2` function) across a frame of NI words streamed in one per cycle. It returns the winning value and its position in the frame. Use it in place of the combinational NI-input tree where area matters more than latency. It sits between a valid/ready word source and a valid/ready result consumer. Unsigned/signed and min/max selection are latched per frame.

## Interface
Parameters:
- `W`, 6, data word width
- `NI`, 7, words per frame (≥1)
- `IDXW`, `$clog2(NI)` (min 1), width of index output

Ports:
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `flush` input 1: synchronous abort of the current frame
- `cfg_us_sel` input 1: 0 = unsigned compare, 1 = signed (two's complement)
- `cfg_min_max_sel` input 1: 0 = find minimum, 1 = find maximum
- `in_valid` input 1: input word valid
- `in_ready` output 1: controller accepts a word this cycle
- `in_data` input W: input word
- `out_valid` output 1: result available
- `out_ready` input 1: consumer accepts result
- `out_result` output W: winning value
- `out_index` output IDXW: frame position (0..NI-1) of the winner
- `busy` output 1: a frame is in progress or a result is pending

## Operation
- Reset is asynchronous and active-low, as decided.
- FSM states: IDLE, ACC, DONE. Reset puts the FSM in IDLE.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = `(state==IDLE || state==ACC) && !flush`.
- IDLE:
  - On an accepted beat: latch `cfg_us_sel` and `cfg_min_max_sel` into the frame mode, set best=`in_data`, best_idx=0, cnt=1.
  - Next state is DONE if NI==1, else ACC.
- ACC:
  - On an accepted beat, compare `in_data` against best using the latched mode.
  - Replace best and set best_idx=cnt only if `in_data` is strictly better (strictly less for min, strictly greater for max).
  - Ties keep the earlier (lower) index.
  - cnt increments on every accepted beat.
  - The beat accepted while cnt==NI-1 moves the FSM to DONE.
- DONE:
  - `out_valid`=1. `out_result`/`out_index` hold best/best_idx stable until the handshake.
  - `out_valid && out_ready` returns the FSM to IDLE.
- Config inputs are ignored outside the first beat of a frame. Changing them mid-frame has no effect on the current frame.
- `flush`:
  - From any state, the FSM goes to IDLE next cycle.
  - Partial or pending results are discarded and `out_valid` drops.
  - No beat is accepted in the flush cycle.
- `busy` = `state != IDLE`.
- Gaps (`in_valid`=0) in IDLE/ACC stall the FSM with no state change.
- cnt width is IDXW+1 bits and never wraps; it is cleared on frame start.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_index`=0, `busy`=0, `in_ready`=1 (IDLE, flush low). Internal best, best_idx and cnt are all 0.
- Throughput is one word per cycle while in IDLE/ACC.
- Latency: `out_valid` rises the cycle after the last beat is accepted.
- The minimum frame period is NI+1 cycles when `out_ready` is held high. `in_ready` is 0 in DONE, so there is no overlap of frames.
- `out_result` and `out_index` are registered and change only on accepted beats or reset. The values from a flushed frame are not presented (`out_valid`=0).
- Simultaneous `flush` and `out_ready` in DONE: the result is dropped, the FSM goes to IDLE, and the event counts as no handshake.
- Reset asserted mid-frame immediately returns the block to its reset values. The next frame restarts at index 0.

## Test plan
- Unsigned max (us=0, mm=1), frame 5,63,0,12,63,0,7 back-to-back, `out_ready`=1 -> `out_result`=63, `out_index`=1; `out_valid` appears 1 cycle after the 7th beat.
- Same frame in the other three modes:
  - unsigned min -> 0, index 2
  - signed max -> 12, index 3
  - signed min -> 63 (−1), index 1
- Config toggled after beat 0 (start unsigned min, switch to signed max) -> result still unsigned min: 0, index 2.
- Random `in_valid` gaps and `out_ready` held low 5 cycles in DONE:
  - `in_ready`=0 throughout DONE.
  - Result held stable.
  - Second frame 1,1,1,1,1,1,1 (min) -> 1, index 0.
- `flush` asserted on beat 4 with `in_valid`=1:
  - The beat is not accepted, `busy`=0 next cycle, no `out_valid`.
  - The next full frame 9,8,7,6,5,4,3 (unsigned min) -> 3, index 6.
- `rst_n` pulsed low asynchronously mid-frame and in DONE -> all outputs return to their reset values immediately. A following frame (unsigned max) 0,0,0,0,0,0,1 -> 1, index 6.
